// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchronizer, whole-frame debounce,
// lowest-code-wins priority encoding and a press/release FSM emitting one strobe per new press.
module keypad_scan #(
  parameter int SCAN_BITS = 16,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [2:0]           DEB_MAX = 3'(DEBOUNCE);
  localparam logic [SCAN_BITS-1:0] CNT_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HELD = 2'b01
  } state_t;

  logic [SCAN_BITS-1:0] cnt;
  logic [1:0]           ci;
  logic [3:0]           rs_meta;
  logic [3:0]           rs;
  logic [15:0]          snap;
  logic [15:0]          prev;
  logic [15:0]          deb;
  logic [2:0]           stable;

  logic                 sample;
  logic                 frame_end;
  logic [15:0]          snap_nx;
  logic [2:0]           stable_nx;
  logic [15:0]          deb_nx;
  logic [3:0]           code;
  logic                 any;

  state_t               state;
  state_t               state_nx;
  logic [3:0]           key_nx;
  logic                 valid_nx;

  assign sample    = &cnt;
  assign frame_end = sample && (ci == 2'd3);
  assign col       = ~(4'b0001 << ci);

  // Snapshot as it will look after this cycle's sample; at frame end this is the complete frame.
  always_comb begin
    snap_nx = snap;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (ci == 2'(c)) snap_nx[4*r + c] = ~rs[r];
        end
      end
    end
  end

  always_comb begin
    stable_nx = stable;
    deb_nx    = deb;
    if (frame_end) begin
      if (snap_nx == prev) stable_nx = (stable == DEB_MAX) ? stable : 3'(stable + 3'd1);
      else                 stable_nx = 3'd0;
      if (stable_nx == DEB_MAX) deb_nx = snap_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      ci      <= 2'd0;
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
      snap    <= '0;
      prev    <= '0;
      deb     <= '0;
      stable  <= 3'd0;
    end else begin
      cnt     <= cnt + CNT_ONE;
      rs_meta <= row;
      rs      <= rs_meta;
      if (sample) begin
        ci   <= ci + 2'd1;
        snap <= snap_nx;
      end
      if (frame_end) begin
        prev   <= snap_nx;
        stable <= stable_nx;
      end
      deb <= deb_nx;
    end
  end

  // The FSM looks at the image deb is taking this cycle, so events land one clock after frame end.
  always_comb begin
    code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (deb_nx[i]) code = 4'(i);
    end
  end

  assign any = |deb_nx;

  always_comb begin
    state_nx = state;
    key_nx   = key;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          key_nx   = code;
          valid_nx = 1'b1;
          state_nx = HELD;
        end
      end
      HELD: begin
        if (!any) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key       <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      key       <= key_nx;
      key_valid <= valid_nx;
    end
  end

  assign key_down = (state == HELD);

endmodule
